// File: rtl/counter_sweep_ctrl_if.sv
// rtl/counter_sweep_ctrl_if.sv - control/status and counter feedback bundle for counter_sweep_ctrl
interface counter_sweep_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] low_bound;
  logic [WIDTH-1:0] high_bound;
  logic [7:0]       num_sweeps;
  logic [WIDTH-1:0] counter_value;
  logic             enable;
  logic             direction;
  logic             busy;
  logic             at_bound;
  logic [7:0]       sweep_count;
  logic             done;
  logic             cfg_err;
  logic             stall_err;

  // Requester / counter side
  modport master (
    output start, abort, low_bound, high_bound, num_sweeps, counter_value,
    input  enable, direction, busy, at_bound, sweep_count, done, cfg_err, stall_err
  );

  // Controller side
  modport slave (
    input  start, abort, low_bound, high_bound, num_sweeps, counter_value,
    output enable, direction, busy, at_bound, sweep_count, done, cfg_err, stall_err
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - closed-loop low/high triangle sweep controller for an up/down counter (optional stall watchdog: SWEEP_TIMEOUT_EN)
module counter_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DWELL   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  counter_sweep_ctrl_if.slave  ctrl
);

  typedef enum logic [2:0] {
    IDLE, SEEK, HOLD_LO, UP, HOLD_HI, DOWN, DONE
  } state_t;

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [7:0]       nsw_q, nsw_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [7:0]       sweep_q, sweep_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             enable, direction;

`ifdef SWEEP_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]    stall_q, stall_d;
  logic [WIDTH-1:0] prev_cv_q;
  logic             stall_err_q, stall_err_d;
`endif

  // State register and latched configuration
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      low_q     <= '0;
      high_q    <= '0;
      nsw_q     <= '0;
      dwell_q   <= '0;
      sweep_q   <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_q     <= low_d;
      high_q    <= high_d;
      nsw_q     <= nsw_d;
      dwell_q   <= dwell_d;
      sweep_q   <= sweep_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef SWEEP_TIMEOUT_EN
  // Watchdog state: stall run length, previous feedback sample, sticky flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q     <= '0;
      prev_cv_q   <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_q     <= stall_d;
      prev_cv_q   <= ctrl.counter_value;
      stall_err_q <= stall_err_d;
    end
  end
`endif

  // Next state and combinational counter drive; enable drops in the cycle the target is seen
  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    high_d    = high_q;
    nsw_d     = nsw_q;
    dwell_d   = dwell_q;
    sweep_d   = sweep_q;
    done_d    = 1'b0;
    cfg_err_d = cfg_err_q;
    enable    = 1'b0;
    direction = 1'b1;
`ifdef SWEEP_TIMEOUT_EN
    stall_d     = '0;
    stall_err_d = stall_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (ctrl.start && !ctrl.abort) begin
          if (ctrl.low_bound >= ctrl.high_bound) begin
            cfg_err_d = 1'b1;
          end else begin
            low_d     = ctrl.low_bound;
            high_d    = ctrl.high_bound;
            nsw_d     = ctrl.num_sweeps;
            sweep_d   = '0;
            cfg_err_d = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
            stall_err_d = 1'b0;
`endif
            state_d   = SEEK;
          end
        end
      end
      SEEK: begin
        enable    = (ctrl.counter_value != low_q);
        direction = !enable || (ctrl.counter_value < low_q);
        if (!enable) begin
          dwell_d = DWELL_LOAD;
          state_d = HOLD_LO;
        end
      end
      HOLD_LO: begin
        if (dwell_q == '0) state_d = UP;
        else               dwell_d = dwell_q - 1'b1;
      end
      UP: begin
        enable = (ctrl.counter_value != high_q);
        if (!enable) begin
          dwell_d = DWELL_LOAD;
          state_d = HOLD_HI;
        end
      end
      HOLD_HI: begin
        if (dwell_q == '0) state_d = DOWN;
        else               dwell_d = dwell_q - 1'b1;
      end
      DOWN: begin
        enable    = (ctrl.counter_value != low_q);
        direction = !enable;
        if (!enable) begin
          sweep_d = (sweep_q == 8'hFF) ? 8'hFF : sweep_q + 8'd1;
          if (nsw_q != 8'd0 && sweep_d == nsw_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            dwell_d = DWELL_LOAD;
            state_d = HOLD_LO;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SWEEP_TIMEOUT_EN
    // A driven counter whose value does not move is stalled
    if (enable && ctrl.counter_value == prev_cv_q) stall_d = stall_q + 1'b1;
    if (stall_d == SW'(TIMEOUT)) begin
      stall_d     = '0;
      stall_err_d = 1'b1;
      done_d      = 1'b0;
      state_d     = IDLE;
    end
`endif

    // Abort wins over everything: stop the counter now, keep the sweep count
    if (ctrl.abort) begin
      enable    = 1'b0;
      direction = 1'b1;
      done_d    = 1'b0;
      sweep_d   = sweep_q;
      state_d   = IDLE;
    end
  end

  assign ctrl.enable      = enable;
  assign ctrl.direction   = direction;
  assign ctrl.busy        = (state_q != IDLE);
  assign ctrl.at_bound    = (state_q == HOLD_LO) || (state_q == HOLD_HI);
  assign ctrl.sweep_count = sweep_q;
  assign ctrl.done        = done_q;
  assign ctrl.cfg_err     = cfg_err_q;
`ifdef SWEEP_TIMEOUT_EN
  assign ctrl.stall_err   = stall_err_q;
`else
  // No watchdog: TIMEOUT is a positive int, so this is a constant 0
  assign ctrl.stall_err   = (TIMEOUT < 0);
`endif

endmodule
